// File: rtl/frac_bcd_serializer_pkg.sv
// -----------------------------------------------------------------------------
// frac_bcd_serializer_pkg
// Shared constants and types for the fraction-to-BCD serializer: FSM state
// encoding, digit width, decimal base and a counter-width helper.
// No ports (package).
// -----------------------------------------------------------------------------
package frac_bcd_serializer_pkg;

  localparam int DIGIT_W  = 4;
  localparam int DEC_BASE = 10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CONV  = 3'd1,
    S_RND   = 3'd2,
    S_CARRY = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  // A single-digit converter still needs a 1-bit counter.
  function automatic int cnt_width(input int n_digits);
    return (n_digits > 1) ? $clog2(n_digits) : 1;
  endfunction

endpackage

// File: rtl/frac_bcd_serializer_if.sv
// -----------------------------------------------------------------------------
// frac_bcd_serializer_if
// Start/busy/done handshake plus data buses of the fraction-to-BCD serializer.
//   iSTART   master->slave  conversion request
//   iFRAC    master->slave  binary fraction 0.F
//   oBUSY    slave->master  converter active
//   oDONE    slave->master  one-cycle result-valid pulse
//   oDIGITS  slave->master  BCD digits, digit k at [4k+3:4k], k=0 = tenths
//   oCARRY   slave->master  rounding overflowed to 1.000...
// -----------------------------------------------------------------------------
interface frac_bcd_serializer_if #(
  parameter int FRAC_W   = 15,
  parameter int N_DIGITS = 7
);

  logic                  iSTART;
  logic [FRAC_W-1:0]     iFRAC;
  logic                  oBUSY;
  logic                  oDONE;
  logic [4*N_DIGITS-1:0] oDIGITS;
  logic                  oCARRY;

  modport master (
    output iSTART, iFRAC,
    input  oBUSY, oDONE, oDIGITS, oCARRY
  );

  modport slave (
    input  iSTART, iFRAC,
    output oBUSY, oDONE, oDIGITS, oCARRY
  );

endinterface

// File: rtl/frac_bcd_serializer_digit_step.sv
// -----------------------------------------------------------------------------
// frac_bcd_serializer_digit_step
// Combinational x10 step of a binary fraction: the integer part of rem*10 is
// the next decimal digit, the fractional part is the new remainder.
//   i_rem       in   FRAC_W   current remainder
//   o_digit     out  4        next decimal digit (always 0..9)
//   o_rem_next  out  FRAC_W   remainder after the step
// -----------------------------------------------------------------------------
module frac_bcd_serializer_digit_step
  import frac_bcd_serializer_pkg::*;
#(
  parameter int FRAC_W = 15
) (
  input  logic [FRAC_W-1:0]  i_rem,
  output logic [DIGIT_W-1:0] o_digit,
  output logic [FRAC_W-1:0]  o_rem_next
);

  logic [FRAC_W+DIGIT_W-1:0] w_ext;
  logic [FRAC_W+DIGIT_W-1:0] w_prod;

  // rem*10 as rem*8 + rem*2; 4 extra bits hold the product without overflow.
  assign w_ext      = {{DIGIT_W{1'b0}}, i_rem};
  assign w_prod     = (w_ext << 3) + (w_ext << 1);
  assign o_digit    = w_prod[FRAC_W+DIGIT_W-1:FRAC_W];
  assign o_rem_next = w_prod[FRAC_W-1:0];

endmodule

// File: rtl/frac_bcd_serializer.sv
// -----------------------------------------------------------------------------
// frac_bcd_serializer
// Converts an unsigned binary fraction 0.F into N_DIGITS decimal BCD digits,
// one digit per clock, with optional round-half-up on the last digit.
//   iCLK    in   clock, rising edge
//   iRST_N  in   asynchronous active-low reset
//   bus     slave modport of frac_bcd_serializer_if (start/busy/done, data)
//
// state | meaning
// IDLE  | waiting for iSTART, results held
// CONV  | produce digit[cnt] from rem*10
// RND   | compute guard digit, decide whether to round up
// CARRY | increment digit[cnt], rippling toward tenths on 9
// FIN   | oDONE pulse, results valid
// -----------------------------------------------------------------------------
module frac_bcd_serializer
  import frac_bcd_serializer_pkg::*;
#(
  parameter int FRAC_W   = 15,
  parameter int N_DIGITS = 7,
  parameter int ROUND    = 1
) (
  input logic                  iCLK,
  input logic                  iRST_N,
  frac_bcd_serializer_if.slave bus
);

  localparam int                 CNT_W      = cnt_width(N_DIGITS);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(N_DIGITS - 1);
  localparam logic [DIGIT_W-1:0] DIGIT_MAX  = DIGIT_W'(DEC_BASE - 1);
  localparam logic [DIGIT_W-1:0] GUARD_HALF = DIGIT_W'(DEC_BASE / 2);

  state_t                             r_state;
  logic [FRAC_W-1:0]                  r_rem;
  logic [CNT_W-1:0]                   r_cnt;
  logic [N_DIGITS-1:0][DIGIT_W-1:0]   r_digits;
  logic                               r_busy;
  logic                               r_done;
  logic                               r_carry;

  logic [DIGIT_W-1:0]                 w_digit;
  logic [FRAC_W-1:0]                  w_rem_next;

  // Shared between CONV (real digits) and RND (guard digit from the final rem).
  frac_bcd_serializer_digit_step #(
    .FRAC_W (FRAC_W)
  ) u_step (
    .i_rem      (r_rem),
    .o_digit    (w_digit),
    .o_rem_next (w_rem_next)
  );

  // oBUSY/oDONE are registered alongside the state so they are exact decodes
  // of the next state: busy whenever not IDLE, done only in FIN.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state  <= S_IDLE;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_digits <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_carry  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.iSTART) begin
            r_rem    <= bus.iFRAC;
            r_cnt    <= '0;
            r_digits <= '0;
            r_carry  <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= S_CONV;
          end
        end

        S_CONV: begin
          r_digits[r_cnt] <= w_digit;
          r_rem           <= w_rem_next;
          if (r_cnt == CNT_LAST) begin
            if (ROUND != 0) begin
              r_state <= S_RND;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_RND: begin
          if (w_digit >= GUARD_HALF) begin
            r_cnt   <= CNT_LAST;
            r_state <= S_CARRY;
          end else begin
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end
        end

        // Least significant digit first; the first non-9 digit absorbs the carry.
        S_CARRY: begin
          if (r_digits[r_cnt] == DIGIT_MAX) begin
            r_digits[r_cnt] <= '0;
            if (r_cnt == '0) begin
              r_carry <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end else begin
            r_digits[r_cnt] <= r_digits[r_cnt] + DIGIT_W'(1);
            r_done          <= 1'b1;
            r_state         <= S_FIN;
          end
        end

        S_FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.oBUSY   = r_busy;
  assign bus.oDONE   = r_done;
  assign bus.oDIGITS = r_digits;
  assign bus.oCARRY  = r_carry;

endmodule

// File: tb/tb_frac_bcd_serializer.sv
// -----------------------------------------------------------------------------
// tb_frac_bcd_serializer
// Three converter instances: sel 0 = N7 truncate, sel 1 = N7 round,
// sel 2 = N3 round. Expected results are queued when a job is started and
// compared when oDONE appears.
// -----------------------------------------------------------------------------
module tb_frac_bcd_serializer;

  logic clk_sys;
  logic rst_b;

  logic [2:0]  start_v;
  logic [14:0] frac_v [3];
  logic [2:0]  done_v;
  logic [2:0]  busy_v;
  logic [2:0]  carry_v;
  logic [27:0] dig_v [3];

  int n_checks;
  int n_pass;

  typedef struct {
    int          sel;
    logic [27:0] digits;
    logic        carry;
    int          lat;
  } exp_t;

  typedef struct {
    int          sel;
    logic [14:0] frac;
    longint      val;
    logic        carry;
    int          lat;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[14];

  frac_bcd_serializer_if #(.FRAC_W(15), .N_DIGITS(7)) if0 ();
  frac_bcd_serializer_if #(.FRAC_W(15), .N_DIGITS(7)) if1 ();
  frac_bcd_serializer_if #(.FRAC_W(15), .N_DIGITS(3)) if2 ();

  frac_bcd_serializer #(.FRAC_W(15), .N_DIGITS(7), .ROUND(0)) u_dut0 (
    .iCLK(clk_sys), .iRST_N(rst_b), .bus(if0));
  frac_bcd_serializer #(.FRAC_W(15), .N_DIGITS(7), .ROUND(1)) u_dut1 (
    .iCLK(clk_sys), .iRST_N(rst_b), .bus(if1));
  frac_bcd_serializer #(.FRAC_W(15), .N_DIGITS(3), .ROUND(1)) u_dut2 (
    .iCLK(clk_sys), .iRST_N(rst_b), .bus(if2));

  assign if0.iSTART = start_v[0];
  assign if1.iSTART = start_v[1];
  assign if2.iSTART = start_v[2];
  assign if0.iFRAC  = frac_v[0];
  assign if1.iFRAC  = frac_v[1];
  assign if2.iFRAC  = frac_v[2];

  assign done_v  = {if2.oDONE,  if1.oDONE,  if0.oDONE};
  assign busy_v  = {if2.oBUSY,  if1.oBUSY,  if0.oBUSY};
  assign carry_v = {if2.oCARRY, if1.oCARRY, if0.oCARRY};
  assign dig_v[0] = if0.oDIGITS;
  assign dig_v[1] = if1.oDIGITS;
  assign dig_v[2] = {16'h0, if2.oDIGITS};

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int nd(input int sel);
    return (sel == 2) ? 3 : 7;
  endfunction

  // Decimal value -> BCD nibbles, tenths (most significant) at nibble 0.
  function automatic logic [27:0] to_bcd(input longint val, input int n);
    logic [27:0] r;
    longint      p;
    r = '0;
    for (int k = 0; k < n; k++) begin
      p = 1;
      for (int i = 0; i < n - 1 - k; i++) p = p * 10;
      r[4*k +: 4] = 4'((val / p) % 10);
    end
    return r;
  endfunction

  function automatic void chk(input string nm, input longint act, input longint exp_v);
    n_checks++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
  endfunction

  // Reference from integer arithmetic: floor(F*10^n/2^15) and guard digit.
  task automatic model(input int sel, input logic [14:0] frac,
                       output longint val, output logic carry, output int lat);
    int     n;
    longint p10, t, g, tmp;
    int     j;
    n = nd(sel);
    p10 = 1;
    for (int i = 0; i < n; i++) p10 = p10 * 10;
    t = (longint'(frac) * p10) >>> 15;
    g = ((longint'(frac) * p10 * 10) >>> 15) % 10;
    val   = t;
    carry = 1'b0;
    lat   = n + 1;
    if (sel != 0) begin
      lat = n + 2;
      if (g >= 5) begin
        tmp = t;
        j = 0;
        while (j < n && (tmp % 10) == 9) begin
          j++;
          tmp = tmp / 10;
        end
        lat = lat + ((j == n) ? n : j + 1);
        val = t + 1;
        if (val == p10) begin
          carry = 1'b1;
          val   = 0;
        end
      end
    end
  endtask

  task automatic do_job(input int sel, input logic [14:0] frac, input longint val,
                        input logic ec, input int el, input string nm);
    exp_t e;
    int   cyc;
    e.sel = sel; e.digits = to_bcd(val, nd(sel)); e.carry = ec; e.lat = el;
    sb.push_back(e);
    start_v[sel] = 1'b1;
    frac_v[sel]  = frac;
    @(posedge clk_sys); #1;
    start_v[sel] = 1'b0;
    frac_v[sel]  = 15'($urandom);
    cyc = 1;
    chk({nm, "_busy"}, longint'(busy_v[sel]), 1);
    while (!done_v[sel] && cyc < 40) begin
      @(posedge clk_sys); #1;
      cyc++;
    end
    if (!done_v[sel]) begin
      chk({nm, "_timeout"}, longint'(done_v[sel]), 1);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      chk({nm, "_digits"},  longint'(dig_v[sel]),   longint'(e.digits));
      chk({nm, "_carry"},   longint'(carry_v[sel]), longint'(e.carry));
      chk({nm, "_latency"}, longint'(cyc),          longint'(e.lat));
    end
    @(posedge clk_sys); #1;
    chk({nm, "_pulse"}, longint'(done_v[sel]), 0);
    chk({nm, "_idle"},  longint'(busy_v[sel]), 0);
  endtask

  initial begin
    exp_t   e;
    longint mv;
    logic   mc;
    int     ml;
    int     nd_cnt;
    int     cyc;
    int     sel;
    logic [14:0] fr;

    n_checks = 0;
    n_pass   = 0;
    start_v  = '0;
    for (int i = 0; i < 3; i++) frac_v[i] = '0;

    //          sel frac      value    carry lat
    vecs[0]  = '{0, 15'h4000, 5000000, 1'b0, 8};
    vecs[1]  = '{0, 15'h7FFF, 9999694, 1'b0, 8};
    vecs[2]  = '{1, 15'h7FFF, 9999695, 1'b0, 10};
    vecs[3]  = '{2, 15'h7FFF, 0,       1'b1, 8};
    vecs[4]  = '{1, 15'h2AAB, 3333435, 1'b0, 9};
    vecs[5]  = '{0, 15'h0000, 0,       1'b0, 8};
    vecs[6]  = '{1, 15'h0000, 0,       1'b0, 9};
    vecs[7]  = '{2, 15'h0001, 0,       1'b0, 5};
    vecs[8]  = '{2, 15'h4000, 500,     1'b0, 5};
    vecs[9]  = '{1, 15'h0001, 305,     1'b0, 9};
    vecs[10] = '{2, 15'h1000, 125,     1'b0, 5};
    vecs[11] = '{2, 15'h0CCD, 100,     1'b0, 5};
    vecs[12] = '{2, 15'h0CC0, 100,     1'b0, 8};
    vecs[13] = '{1, 15'h6000, 7500000, 1'b0, 9};

    rst_b = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    for (int s = 0; s < 3; s++) begin
      chk("rst_busy",   longint'(busy_v[s]),  0);
      chk("rst_done",   longint'(done_v[s]),  0);
      chk("rst_digits", longint'(dig_v[s]),   0);
      chk("rst_carry",  longint'(carry_v[s]), 0);
    end
    rst_b = 1'b1;
    @(posedge clk_sys); #1;

    for (int i = 0; i < 14; i++)
      do_job(vecs[i].sel, vecs[i].frac, vecs[i].val, vecs[i].carry, vecs[i].lat,
             $sformatf("vec%0d", i));

    for (int r = 0; r < 30; r++) begin
      sel = r % 3;
      fr  = 15'($urandom);
      model(sel, fr, mv, mc, ml);
      do_job(sel, fr, mv, mc, ml, $sformatf("rnd%0d", r));
    end

    // iSTART pulsed every busy cycle with changing iFRAC: one result, first value.
    e.sel = 1; e.digits = to_bcd(3333435, 7); e.carry = 1'b0; e.lat = 9;
    sb.push_back(e);
    start_v[1] = 1'b1;
    frac_v[1]  = 15'h2AAB;
    nd_cnt = 0;
    cyc    = 0;
    repeat (30) begin
      @(posedge clk_sys); #1;
      cyc++;
      if (done_v[1]) begin
        nd_cnt++;
        if (nd_cnt == 1) begin
          e = sb.pop_front();
          chk("hold_digits",  longint'(dig_v[1]),   longint'(e.digits));
          chk("hold_carry",   longint'(carry_v[1]), longint'(e.carry));
          chk("hold_latency", longint'(cyc),        longint'(e.lat));
        end
        start_v[1] = 1'b0;
      end else if (busy_v[1]) begin
        start_v[1] = ~start_v[1];
        frac_v[1]  = 15'($urandom);
      end else begin
        start_v[1] = 1'b0;
      end
    end
    chk("hold_done_count", longint'(nd_cnt), 1);
    if (sb.size() != 0) void'(sb.pop_front());

    // Back-to-back with iSTART held high: one idle cycle between jobs.
    start_v[2] = 1'b1;
    frac_v[2]  = 15'h4000;
    cyc = 0;
    while (!done_v[2] && cyc < 40) begin
      @(posedge clk_sys); #1;
      cyc++;
    end
    chk("b2b_first_done", longint'(done_v[2]), 1);
    chk("b2b_first_dig",  longint'(dig_v[2]),  longint'(to_bcd(500, 3)));
    @(posedge clk_sys); #1;
    chk("b2b_idle_gap", longint'(busy_v[2]), 0);
    @(posedge clk_sys); #1;
    chk("b2b_reaccept", longint'(busy_v[2]), 1);
    start_v[2] = 1'b0;
    frac_v[2]  = 15'h1000;
    cyc = 0;
    while (!done_v[2] && cyc < 40) begin
      @(posedge clk_sys); #1;
      cyc++;
    end
    chk("b2b_second_dig", longint'(dig_v[2]), longint'(to_bcd(500, 3)));
    chk("b2b_second_lat", longint'(cyc), 4);
    repeat (2) @(posedge clk_sys);
    #1;

    // Asynchronous reset while CONV has cnt=3 (digits 0..2 already written).
    start_v[0] = 1'b1;
    frac_v[0]  = 15'h7FFF;
    @(posedge clk_sys); #1;
    start_v[0] = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("abort_pre_digits", longint'(dig_v[0][11:0]), 12'h999);
    rst_b = 1'b0;
    #1;
    chk("abort_busy",   longint'(busy_v[0]),  0);
    chk("abort_done",   longint'(done_v[0]),  0);
    chk("abort_digits", longint'(dig_v[0]),   0);
    chk("abort_carry",  longint'(carry_v[0]), 0);
    repeat (2) @(posedge clk_sys);
    #1;
    rst_b = 1'b1;
    nd_cnt = 0;
    repeat (12) begin
      @(posedge clk_sys); #1;
      if (done_v[0]) nd_cnt++;
    end
    chk("abort_no_done", longint'(nd_cnt), 0);
    do_job(0, 15'h4000, 5000000, 1'b0, 8, "post_abort");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
